// File: rtl/jtag_tap_ctrl.sv
// JTAG TAP controller: 16-state IEEE 1149.1 FSM, IR_W-bit instruction
// register with decode, BYPASS and IDCODE data registers, scan-chain
// strobes/selects and the TDO output mux.
module jtag_tap_ctrl #(
  parameter int unsigned     IR_W      = 4,
  parameter logic [31:0]     IDCODE    = 32'h1234_5677,
  parameter logic [IR_W-1:0] OP_EXTEST = IR_W'(4'h0),
  parameter logic [IR_W-1:0] OP_IDCODE = IR_W'(4'h1),
  parameter logic [IR_W-1:0] OP_SAMPLE = IR_W'(4'h2),
  parameter logic [IR_W-1:0] OP_BIST   = IR_W'(4'h8),
  parameter logic [IR_W-1:0] OP_BYPASS = '1
) (
  input  logic            ck,
  input  logic            reset,
  input  logic            TMS,
  input  logic            TDI,
  output logic            TDO,
  output logic            tdo_en,
  output logic [3:0]      state,
  output logic [IR_W-1:0] inst,
  output logic            capture_dr,
  output logic            shift_dr,
  output logic            update_dr,
  output logic            hold,
  output logic            sel_bsr,
  output logic            sel_bist,
  input  logic            bsr_tdo,
  input  logic            bist_tdo,
  output logic            bist_start
);

  typedef enum logic [3:0] {
    ST_TLR    = 4'hF, ST_RTI    = 4'hC,
    ST_SEL_DR = 4'h7, ST_CAP_DR = 4'h6, ST_SH_DR  = 4'h2, ST_EX1_DR = 4'h1,
    ST_PAU_DR = 4'h3, ST_EX2_DR = 4'h0, ST_UPD_DR = 4'h5,
    ST_SEL_IR = 4'h4, ST_CAP_IR = 4'hE, ST_SH_IR  = 4'hA, ST_EX1_IR = 4'h9,
    ST_PAU_IR = 4'hB, ST_EX2_IR = 4'h8, ST_UPD_IR = 4'hD
  } tap_state_t;

  tap_state_t      cur;
  logic [IR_W-1:0] ir_sr;
  logic            bypass;
  logic [31:0]     idcode_sr;
  logic            sel_idcode;
  logic            sel_bypass;
  logic            dr_tdo;

  function automatic tap_state_t next_state(input tap_state_t s, input logic tms);
    case (s)
      ST_TLR:    return tms ? ST_TLR    : ST_RTI;
      ST_RTI:    return tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_DR: return tms ? ST_SEL_IR : ST_CAP_DR;
      ST_CAP_DR: return tms ? ST_EX1_DR : ST_SH_DR;
      ST_SH_DR:  return tms ? ST_EX1_DR : ST_SH_DR;
      ST_EX1_DR: return tms ? ST_UPD_DR : ST_PAU_DR;
      ST_PAU_DR: return tms ? ST_EX2_DR : ST_PAU_DR;
      ST_EX2_DR: return tms ? ST_UPD_DR : ST_SH_DR;
      ST_UPD_DR: return tms ? ST_SEL_DR : ST_RTI;
      ST_SEL_IR: return tms ? ST_TLR    : ST_CAP_IR;
      ST_CAP_IR: return tms ? ST_EX1_IR : ST_SH_IR;
      ST_SH_IR:  return tms ? ST_EX1_IR : ST_SH_IR;
      ST_EX1_IR: return tms ? ST_UPD_IR : ST_PAU_IR;
      ST_PAU_IR: return tms ? ST_EX2_IR : ST_PAU_IR;
      ST_EX2_IR: return tms ? ST_UPD_IR : ST_SH_IR;
      ST_UPD_IR: return tms ? ST_SEL_DR : ST_RTI;
      default:   return ST_TLR;
    endcase
  endfunction

  // TAP state, instruction/data registers and the BIST start pulse; each
  // register action takes effect on the edge that ends its state.
  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      cur        <= ST_TLR;
      inst       <= OP_IDCODE;
      ir_sr      <= IR_W'(1);
      bypass     <= 1'b0;
      idcode_sr  <= IDCODE;
      bist_start <= 1'b0;
    end else begin
      cur        <= next_state(cur, TMS);
      bist_start <= (cur == ST_UPD_DR) && (inst == OP_BIST);
      case (cur)
        ST_TLR: begin
          inst      <= OP_IDCODE;
          ir_sr     <= IR_W'(1);
          bypass    <= 1'b0;
          idcode_sr <= IDCODE;
        end
        ST_CAP_IR: ir_sr <= IR_W'(1);
        ST_SH_IR:  ir_sr <= {TDI, ir_sr[IR_W-1:1]};
        ST_UPD_IR: inst  <= ir_sr;
        ST_CAP_DR: begin
          bypass    <= 1'b0;
          idcode_sr <= IDCODE;
        end
        ST_SH_DR: begin
          bypass    <= TDI;
          idcode_sr <= {TDI, idcode_sr[31:1]};
        end
        default: ;
      endcase
    end
  end

  assign state      = cur;
  assign capture_dr = (cur == ST_CAP_DR);
  assign shift_dr   = (cur == ST_SH_DR);
  assign update_dr  = (cur == ST_UPD_DR);
  assign tdo_en     = (cur == ST_SH_DR) || (cur == ST_SH_IR);
  assign hold       = (inst == OP_EXTEST);
  assign sel_bsr    = (inst == OP_EXTEST) || (inst == OP_SAMPLE);
  assign sel_bist   = (inst == OP_BIST);
  assign sel_idcode = (inst == OP_IDCODE);
  // Undefined opcodes fall back to the 1-bit bypass register.
  assign sel_bypass = (inst == OP_BYPASS) || !(sel_bsr || sel_bist || sel_idcode);

  // Data-register select and TDO mux; TDO is driven only in the shift states.
  always_comb begin
    dr_tdo = 1'b0;
    if (sel_idcode)      dr_tdo = idcode_sr[0];
    else if (sel_bsr)    dr_tdo = bsr_tdo;
    else if (sel_bist)   dr_tdo = bist_tdo;
    else if (sel_bypass) dr_tdo = bypass;

    TDO = 1'b0;
    if (cur == ST_SH_IR)      TDO = ir_sr[0];
    else if (cur == ST_SH_DR) TDO = dr_tdo;
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: a per-cycle vector table for IR loads and
// DR shifts, plus hand sequences for IDCODE readout, async reset and 5xTMS.
module tb_jtag_tap_ctrl;

  logic       ck = 1'b0;
  logic       reset, TMS, TDI, bsr_tdo, bist_tdo;
  logic       TDO, tdo_en, capture_dr, shift_dr, update_dr;
  logic       hold, sel_bsr, sel_bist, bist_start;
  logic [3:0] state, inst;

  jtag_tap_ctrl dut (
    .ck(ck), .reset(reset), .TMS(TMS), .TDI(TDI), .TDO(TDO), .tdo_en(tdo_en),
    .state(state), .inst(inst), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .hold(hold), .sel_bsr(sel_bsr), .sel_bist(sel_bist),
    .bsr_tdo(bsr_tdo), .bist_tdo(bist_tdo), .bist_start(bist_start)
  );

  always #5 ck = ~ck;

  typedef struct {
    logic       tms, tdi, bsr, bist;
    logic [3:0] st;
    logic       tdo;
    logic [3:0] inst;
    logic       bs;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic tms, input logic tdi, input logic bsr, input logic bist,
                     input logic [3:0] st, input logic tdo, input logic [3:0] in_inst,
                     input logic bs);
    vec_t v;
    v.tms = tms; v.tdi = tdi; v.bsr = bsr; v.bist = bist;
    v.st = st; v.tdo = tdo; v.inst = in_inst; v.bs = bs;
    vecs.push_back(v);
  endtask

  // From RTI: shift val into the IR LSB-first, update, end in RTI.
  task automatic ir_load(input logic [3:0] val, input logic [3:0] old, input logic bs_first);
    add(1, 0, 0, 0, 4'hC, 0, old, bs_first);
    add(1, 0, 0, 0, 4'h7, 0, old, 0);
    add(0, 0, 0, 0, 4'h4, 0, old, 0);
    add(0, 0, 0, 0, 4'hE, 0, old, 0);
    for (int i = 0; i < 4; i++)
      add(i == 3, val[i], 0, 0, 4'hA, i == 0, old, 0);
    add(1, 0, 0, 0, 4'h9, 0, old, 0);
    add(0, 0, 0, 0, 4'hD, 0, old, 0);
  endtask

  // From RTI: n DR shift cycles with hand-computed TDO, via Ex1DR/UpdDR to RTI.
  task automatic dr_shift(input int n, input logic [7:0] tdi, input logic [7:0] bsr,
                          input logic [7:0] bist, input logic [7:0] etdo,
                          input logic [3:0] in_inst, input logic bs_first);
    add(1, 0, 0, 0, 4'hC, 0, in_inst, bs_first);
    add(0, 0, 0, 0, 4'h7, 0, in_inst, 0);
    add(0, 0, 0, 0, 4'h6, 0, in_inst, 0);
    for (int i = 0; i < n; i++)
      add(i == n - 1, tdi[i], bsr[i], bist[i], 4'h2, etdo[i], in_inst, 0);
    add(1, 0, 0, 0, 4'h1, 0, in_inst, 0);
    add(0, 0, 0, 0, 4'h5, 0, in_inst, 0);
  endtask

  task automatic step(input logic tms, input logic tdi);
    TMS = tms; TDI = tdi;
    @(posedge ck); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] word;
    int          cap_cnt;
    vec_t        v;

    // Expected cycle table, starting in TLR right after reset.
    add(0, 0, 0, 0, 4'hF, 0, 4'h1, 0);
    ir_load(4'hF, 4'h1, 0);
    dr_shift(4, 8'b1101, 8'b0, 8'b0, 8'b1010, 4'hF, 0);
    ir_load(4'h5, 4'hF, 0);
    dr_shift(4, 8'b1101, 8'b0, 8'b0, 8'b1010, 4'h5, 0);
    ir_load(4'h0, 4'h5, 0);
    dr_shift(3, 8'b010, 8'b101, 8'b010, 8'b101, 4'h0, 0);
    ir_load(4'h2, 4'h0, 0);
    dr_shift(2, 8'b00, 8'b10, 8'b01, 8'b10, 4'h2, 0);
    ir_load(4'h8, 4'h2, 0);
    dr_shift(2, 8'b00, 8'b10, 8'b01, 8'b01, 4'h8, 0);
    add(0, 0, 0, 0, 4'hC, 0, 4'h8, 1);
    add(0, 0, 0, 0, 4'hC, 0, 4'h8, 0);

    reset = 1'b1; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0; bist_tdo = 1'b0;
    repeat (2) @(posedge ck);
    #1 reset = 1'b0;

    foreach (vecs[k]) begin
      v = vecs[k];
      TMS = v.tms; TDI = v.tdi; bsr_tdo = v.bsr; bist_tdo = v.bist;
      #1;
      chk($sformatf("row%0d state", k),      32'(state),      32'(v.st));
      chk($sformatf("row%0d inst", k),       32'(inst),       32'(v.inst));
      chk($sformatf("row%0d tdo", k),        32'(TDO),        32'(v.tdo));
      chk($sformatf("row%0d capture_dr", k), 32'(capture_dr), 32'(v.st == 4'h6));
      chk($sformatf("row%0d shift_dr", k),   32'(shift_dr),   32'(v.st == 4'h2));
      chk($sformatf("row%0d update_dr", k),  32'(update_dr),  32'(v.st == 4'h5));
      chk($sformatf("row%0d tdo_en", k),     32'(tdo_en),     32'(v.st == 4'h2 || v.st == 4'hA));
      chk($sformatf("row%0d hold", k),       32'(hold),       32'(v.inst == 4'h0));
      chk($sformatf("row%0d sel_bsr", k),    32'(sel_bsr),    32'(v.inst == 4'h0 || v.inst == 4'h2));
      chk($sformatf("row%0d sel_bist", k),   32'(sel_bist),   32'(v.inst == 4'h8));
      chk($sformatf("row%0d bist_start", k), 32'(bist_start), 32'(v.bs));
      @(posedge ck); #1;
    end

    // Abort a partial IR shift with async reset: inst returns to IDCODE.
    bsr_tdo = 1'b0; bist_tdo = 1'b0;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("abort_ir pre state", 32'(state), 32'hA);
    step(0, 1); step(0, 1);
    reset = 1'b1; #1;
    chk("abort_ir state", 32'(state), 32'hF);
    chk("abort_ir inst",  32'(inst),  32'h1);
    @(posedge ck); #1 reset = 1'b0;

    // IDCODE readout, LSB first, with a single capture_dr cycle.
    cap_cnt = 0;
    word    = '0;
    foreach (word[i]) begin end
    TMS = 0; TDI = 0; #1; if (capture_dr) cap_cnt++; @(posedge ck); #1;
    TMS = 1; #1; if (capture_dr) cap_cnt++; @(posedge ck); #1;
    TMS = 0; #1; if (capture_dr) cap_cnt++; @(posedge ck); #1;
    TMS = 0; #1; if (capture_dr) cap_cnt++; @(posedge ck); #1;
    for (int i = 0; i < 32; i++) begin
      TMS = 0; TDI = 0; #1;
      word[i] = TDO;
      if (capture_dr) cap_cnt++;
      @(posedge ck); #1;
    end
    chk("idcode word", word, 32'h1234_5677);
    chk("idcode capture count", 32'(cap_cnt), 32'd1);
    chk("idcode end state", 32'(state), 32'h2);

    // Async reset mid Shift-DR takes effect without a clock edge.
    #2 reset = 1'b1; #1;
    chk("async rst state",    32'(state),    32'hF);
    chk("async rst inst",     32'(inst),     32'h1);
    chk("async rst shift_dr", 32'(shift_dr), 32'h0);
    chk("async rst tdo_en",   32'(tdo_en),   32'h0);
    @(posedge ck); #1 reset = 1'b0;

    // Five TMS=1 edges from Shift-DR reach TLR.
    step(0, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("tms5 start", 32'(state), 32'h2);
    step(1, 0); step(1, 0); step(1, 0); step(1, 0);
    chk("tms5 after4", 32'(state), 32'h4);
    step(1, 0);
    chk("tms5 after5", 32'(state), 32'hF);
    chk("tms5 inst", 32'(inst), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
